// File: rtl/span_sequencer.sv
// span_sequencer: upstream scanline stage of the rasterizer.
// Walks a trapezoid top to bottom, interpolating the left/right edges in
// Q16.FRAC_BITS, and hands one span per row to the horizontal span stepper
// over a start/done handshake.
// Optional build macro: SPAN_CLIP_EN (clamp span x to the screen, skip rows
// below the screen).
module span_sequencer #(
  parameter int FRAC_BITS = 8,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_enb,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [15:0]             y_top,
  input  logic [15:0]             y_bot,
  input  logic [15:0]             xl0,
  input  logic [15:0]             xr0,
  input  logic [16+FRAC_BITS-1:0] dxl,
  input  logic [16+FRAC_BITS-1:0] dxr,
  output logic                    span_start,
  output logic [15:0]             span_start_x,
  output logic [15:0]             span_end_x,
  output logic [15:0]             span_y,
  input  logic                    span_done,
  output logic                    done
);

  localparam int AW = 16 + FRAC_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_STEP
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   y_cur_q, y_cur_d;
  logic [15:0]   y_bot_q, y_bot_d;
  logic [AW-1:0] xl_q, xl_d;
  logic [AW-1:0] xr_q, xr_d;
  logic [AW-1:0] dxl_q, dxl_d;
  logic [AW-1:0] dxr_q, dxr_d;

  logic [15:0]   xl_int, xr_int;
  logic          row_skip;
  logic          last_row;

  // Integer part is a plain truncation: floor of the two's-complement value.
  assign xl_int   = xl_q[AW-1:FRAC_BITS];
  assign xr_int   = xr_q[AW-1:FRAC_BITS];
  assign last_row = (y_cur_q == y_bot_q);

`ifdef SPAN_CLIP_EN
  localparam logic [15:0] XMAX = 16'(SCREEN_W - 1);
  localparam logic [15:0] YLIM = 16'(SCREEN_H);

  // Integer part treated as signed: negatives pin to 0, large values to XMAX.
  function automatic logic [15:0] clamp_x(input logic [15:0] v);
    if (v[15])
      return 16'd0;
    else if (v > XMAX)
      return XMAX;
    else
      return v;
  endfunction

  assign span_start_x = clamp_x(xl_int);
  assign span_end_x   = clamp_x(xr_int);
  assign row_skip     = (y_cur_q >= YLIM);
`else
  assign span_start_x = xl_int;
  assign span_end_x   = xr_int;
  assign row_skip     = 1'b0;
`endif

  // Span outputs come straight from the row registers, which only move in
  // IDLE (accept) and STEP, so they hold from ISSUE until the stepper is done.
  assign span_y    = y_cur_q;
  assign cmd_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_IDLE);

  // State and datapath registers; everything advances only on enabled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_cur_q <= '0;
      y_bot_q <= '0;
      xl_q    <= '0;
      xr_q    <= '0;
      dxl_q   <= '0;
      dxr_q   <= '0;
    end else if (clk_enb) begin
      state_q <= state_d;
      y_cur_q <= y_cur_d;
      y_bot_q <= y_bot_d;
      xl_q    <= xl_d;
      xr_q    <= xr_d;
      dxl_q   <= dxl_d;
      dxr_q   <= dxr_d;
    end
  end

  // Next-state, row stepping and the span_start strobe.
  always_comb begin
    state_d    = state_q;
    y_cur_d    = y_cur_q;
    y_bot_d    = y_bot_q;
    xl_d       = xl_q;
    xr_d       = xr_q;
    dxl_d      = dxl_q;
    dxr_d      = dxr_q;
    span_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          y_bot_d = y_bot;
          y_cur_d = y_top;
          xl_d    = {xl0, {FRAC_BITS{1'b0}}};
          xr_d    = {xr0, {FRAC_BITS{1'b0}}};
          dxl_d   = dxl;
          dxr_d   = dxr;
          // An empty command parks in WAIT_DONE where y_cur > y_bot exits
          // straight back to IDLE without touching the stepper.
          state_d = (y_bot < y_top) ? S_WAIT_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (row_skip) begin
          state_d = last_row ? S_IDLE : S_STEP;
        end else begin
          span_start = 1'b1;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!span_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (y_cur_q > y_bot_q)
          state_d = S_IDLE;
        else if (span_done)
          state_d = last_row ? S_IDLE : S_STEP;
      end
      S_STEP: begin
        // Compare-for-equality ends the walk, so y_cur never wraps at 0xFFFF.
        y_cur_d = y_cur_q + 16'd1;
        xl_d    = xl_q + dxl_q;
        xr_d    = xr_q + dxr_q;
        state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_span_sequencer.sv
// Directed bench for span_sequencer with a small span-stepper model.
module tb_span_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_enb = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] y_top = '0, y_bot = '0, xl0 = '0, xr0 = '0;
  logic [23:0] dxl = '0, dxr = '0;
  logic        span_start;
  logic [15:0] span_start_x, span_end_x, span_y;
  logic        span_done = 1'b1;
  logic        done;

  int passed = 0;
  int total  = 0;
  logic [47:0] spans[$];

  int ack_dly  = 0;
  int busy_dly = 3;
  int sc = 0;
  int ph = 0;

  span_sequencer #(.FRAC_BITS(8), .SCREEN_W(640), .SCREEN_H(480)) dut (
    .clk(clk), .rst(rst), .clk_enb(clk_enb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .y_top(y_top), .y_bot(y_bot), .xl0(xl0), .xr0(xr0),
    .dxl(dxl), .dxr(dxr),
    .span_start(span_start), .span_start_x(span_start_x),
    .span_end_x(span_end_x), .span_y(span_y),
    .span_done(span_done), .done(done)
  );

  always #5 clk = ~clk;

  // Stepper model: take the span, drop done after ack_dly, raise after busy_dly.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0;
      sc <= 0;
      span_done <= 1'b1;
    end else if (clk_enb) begin
      case (ph)
        0: if (span_start) begin sc <= ack_dly; ph <= 1; end
        1: if (sc == 0) begin span_done <= 1'b0; sc <= busy_dly; ph <= 2; end
           else sc <= sc - 1;
        default: if (sc == 0) begin span_done <= 1'b1; ph <= 0; end
                 else sc <= sc - 1;
      endcase
    end
  end

  // Record each span handed to the stepper.
  always @(posedge clk) begin
    if (!rst && clk_enb && span_start)
      spans.push_back({span_start_x, span_end_x, span_y});
  end

  task automatic send_cmd(input logic [15:0] yt, input logic [15:0] yb,
                          input logic [15:0] l0, input logic [15:0] r0,
                          input logic [23:0] dl, input logic [23:0] dr);
    @(negedge clk);
    y_top = yt; y_bot = yb; xl0 = l0; xr0 = r0; dxl = dl; dxr = dr;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) begin
      total++;
      $display("FAIL wait_idle timeout: done=%b want 1", done);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); else passed++;
    total++; if (done !== 1'b1) $display("FAIL rst_done got %b want 1", done); else passed++;
    total++; if (span_start !== 1'b0) $display("FAIL rst_span_start got %b want 0", span_start); else passed++;
    total++; if ({span_start_x, span_end_x, span_y} !== 48'h0)
      $display("FAIL rst_span_out got %h want 0", {span_start_x, span_end_x, span_y}); else passed++;
  endtask

  task automatic test_rect();
    logic [47:0] e[3];
    logic [47:0] g;
    e[0] = {16'd5, 16'd20, 16'd10};
    e[1] = {16'd5, 16'd20, 16'd11};
    e[2] = {16'd5, 16'd20, 16'd12};
    spans.delete();
    send_cmd(16'd10, 16'd12, 16'd5, 16'd20, 24'h0, 24'h0);
    total++; if (done !== 1'b0) $display("FAIL rect_busy done got %b want 0", done); else passed++;
    wait_idle(200);
    total++; if (spans.size() != 3) $display("FAIL rect_count got %0d want 3", spans.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      g = (i < spans.size()) ? spans[i] : 48'hx;
      total++; if (g !== e[i]) $display("FAIL rect_span%0d got %h want %h", i, g, e[i]); else passed++;
    end
    total++; if (cmd_ready !== 1'b1) $display("FAIL rect_ready got %b want 1", cmd_ready); else passed++;
  endtask

  task automatic test_slopes();
    logic [47:0] e[3];
    logic [47:0] g;
    e[0] = {16'd0, 16'd10, 16'd0};
    e[1] = {16'd1, 16'd9,  16'd1};
    e[2] = {16'd3, 16'd8,  16'd2};
    spans.delete();
    send_cmd(16'd0, 16'd2, 16'd0, 16'd10, 24'h000180, 24'hFFFF00);
    wait_idle(200);
    total++; if (spans.size() != 3) $display("FAIL slope_count got %0d want 3", spans.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      g = (i < spans.size()) ? spans[i] : 48'hx;
      total++; if (g !== e[i]) $display("FAIL slope_span%0d got %h want %h", i, g, e[i]); else passed++;
    end
  endtask

  task automatic test_empty_single();
    spans.delete();
    send_cmd(16'd5, 16'd4, 16'd1, 16'd2, 24'h0, 24'h0);
    @(posedge clk); #1;
    total++; if (done !== 1'b1) $display("FAIL empty_done got %b want 1", done); else passed++;
    repeat (4) @(negedge clk);
    total++; if (spans.size() != 0) $display("FAIL empty_spans got %0d want 0", spans.size()); else passed++;
    send_cmd(16'd7, 16'd7, 16'd3, 16'd4, 24'h0, 24'h0);
    wait_idle(200);
    total++; if (spans.size() != 1) $display("FAIL single_count got %0d want 1", spans.size()); else passed++;
    total++; if (spans.size() > 0 && spans[0] !== {16'd3, 16'd4, 16'd7})
      $display("FAIL single_span got %h want %h", spans[0], {16'd3, 16'd4, 16'd7}); else passed++;
  endtask

  task automatic test_clk_enb();
    spans.delete();
    busy_dly = 8;
    send_cmd(16'd30, 16'd30, 16'd2, 16'd9, 24'h0, 24'h0);
    for (int k = 0; k < 50 && span_done; k++) @(negedge clk);
    @(negedge clk);
    clk_enb = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({done, cmd_ready, span_start, span_done, span_start_x, span_end_x, span_y} !==
          {4'b0000, 16'd2, 16'd9, 16'd30})
        $display("FAIL cke_hold%0d got %b%b%b%b %h %h %h want 0000 0002 0009 001e", k,
                 done, cmd_ready, span_start, span_done, span_start_x, span_end_x, span_y);
      else passed++;
    end
    clk_enb = 1'b1;
    wait_idle(200);
    total++; if (spans.size() != 1) $display("FAIL cke_count got %0d want 1", spans.size()); else passed++;
    busy_dly = 3;
  endtask

  task automatic test_slow_ack();
    spans.delete();
    ack_dly = 4;
    send_cmd(16'd31, 16'd31, 16'd2, 16'd9, 24'h0, 24'h0);
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      total++;
      if ({span_start_x, span_end_x, span_y} !== {16'd2, 16'd9, 16'd31})
        $display("FAIL ack_stable got %h %h %h want 0002 0009 001f", span_start_x, span_end_x, span_y);
      else passed++;
    end
    wait_idle(100);
    total++; if (spans.size() != 1) $display("FAIL ack_count got %0d want 1", spans.size()); else passed++;
    ack_dly = 0;
  endtask

  task automatic test_reset_mid();
    spans.delete();
    busy_dly = 8;
    send_cmd(16'd20, 16'd23, 16'd1, 16'd4, 24'h0, 24'h0);
    for (int k = 0; k < 200 && !(spans.size() == 2 && !span_done); k++) @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({cmd_ready, done, span_start, span_start_x, span_end_x, span_y} !== {3'b110, 48'h0})
      $display("FAIL midrst_out got %b%b%b %h %h %h want 110 0 0 0", cmd_ready, done, span_start,
               span_start_x, span_end_x, span_y);
    else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    busy_dly = 3;
    repeat (20) @(negedge clk);
    total++; if (spans.size() != 2) $display("FAIL midrst_nospan got %0d want 2", spans.size()); else passed++;
    send_cmd(16'd40, 16'd40, 16'd3, 16'd6, 24'h0, 24'h0);
    wait_idle(200);
    total++; if (spans.size() != 3 || spans[spans.size()-1] !== {16'd3, 16'd6, 16'd40})
      $display("FAIL midrst_new got n=%0d last=%h want n=3 %h", spans.size(),
               spans[spans.size()-1], {16'd3, 16'd6, 16'd40}); else passed++;
  endtask

  task automatic test_clip_edge();
    logic [47:0] g;
    spans.delete();
    send_cmd(16'd479, 16'd480, 16'd0, 16'd700, 24'hFFFE00, 24'h0);
    wait_idle(200);
`ifdef SPAN_CLIP_EN
    total++; if (spans.size() != 1) $display("FAIL clip_count got %0d want 1", spans.size()); else passed++;
    g = (spans.size() > 0) ? spans[0] : 48'hx;
    total++; if (g !== {16'd0, 16'd639, 16'd479}) $display("FAIL clip_row479 got %h want %h", g, {16'd0, 16'd639, 16'd479}); else passed++;
`else
    total++; if (spans.size() != 2) $display("FAIL edge_count got %0d want 2", spans.size()); else passed++;
    g = (spans.size() > 0) ? spans[0] : 48'hx;
    total++; if (g !== {16'd0, 16'd700, 16'd479}) $display("FAIL edge_row479 got %h want %h", g, {16'd0, 16'd700, 16'd479}); else passed++;
    g = (spans.size() > 1) ? spans[1] : 48'hx;
    total++; if (g !== {16'hFFFE, 16'd700, 16'd480}) $display("FAIL edge_row480 got %h want %h", g, {16'hFFFE, 16'd700, 16'd480}); else passed++;
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_rect();
    test_slopes();
    test_empty_single();
    test_clk_enb();
    test_slow_ack();
    test_reset_mid();
    test_clip_edge();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
